cpu_muldiv_seq: RTL and testbench

//  Iterative multiply/divide sequencer beside the execute-stage ALU. Accepts one

---
 rtl/cpu_muldiv_seq_if.sv | 24 ++
 rtl/cpu_muldiv_seq.sv | 116 +++++++++++
 tb/tb_cpu_muldiv_seq.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_muldiv_seq_if.sv
// Handshake bundle between decode/execute and the iterative mul/div sequencer.
// The master is the pipeline side; the slave is cpu_muldiv_seq.
interface cpu_muldiv_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start_2a;
    logic [1:0]       op_2a;
    logic [WIDTH-1:0] a_2a;
    logic [WIDTH-1:0] b_2a;
    logic             stall_2a;
    logic             busy;
    logic             valid_3a;
    logic [WIDTH-1:0] result_3a;

    modport master (
        output start_2a, op_2a, a_2a, b_2a,
        input  stall_2a, busy, valid_3a, result_3a
    );

    modport slave (
        input  start_2a, op_2a, a_2a, b_2a,
        output stall_2a, busy, valid_3a, result_3a
    );
endinterface

// File: rtl/cpu_muldiv_seq.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU sequencer, one bit per cycle.
// acc/lo form a shared shift pair: {hi,lo} product for multiply, {rem,quot} for divide.
module cpu_muldiv_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              kill_4a,
    cpu_muldiv_seq_if.slave   mds
);
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] final_res;
    logic             accept;

    // Multiply: add a into the high half when the next multiplier bit is set, then shift right.
    assign mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    // Divide: bring the next dividend bit into the partial remainder and trial-subtract.
    assign div_shift = {acc_q, lo_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    // MULHU and REMU live in acc, MUL and DIVU in lo.
    assign final_res = op_q[0] ? acc_q : lo_q;
    assign accept    = (state_q == StIdle) && mds.start_2a && !kill_4a;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        result_d = result_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    op_d    = mds.op_2a;
                    acc_d   = '0;
                    if (mds.op_2a[1]) begin
                        opnd_d = mds.b_2a;
                        lo_d   = mds.a_2a;
                    end else begin
                        opnd_d = mds.a_2a;
                        lo_d   = mds.b_2a;
                    end
                end
            end
            StRun: begin
                if (kill_4a) begin
                    state_d = StIdle;
                end else begin
                    if (op_q[1]) begin
                        // Remainder stays below the divisor, so the low WIDTH bits are exact.
                        acc_d = div_ge ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0];
                        lo_d  = {lo_q[WIDTH-2:0], div_ge};
                    end else begin
                        acc_d = mul_sum[WIDTH:1];
                        lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                if (!kill_4a) begin
                    result_d = final_res;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            result_q <= result_d;
        end
    end

    // A kill in DONE flushes the 3a instruction, so its result never becomes visible.
    assign mds.valid_3a  = (state_q == StDone) && !kill_4a;
    assign mds.result_3a = mds.valid_3a ? final_res : result_q;
    assign mds.stall_2a  = accept || (state_q == StRun);
    assign mds.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_cpu_muldiv_seq.sv
// Directed bench for cpu_muldiv_seq: vector table for the arithmetic, plus hand
// sequences for kill, held start, simultaneous start/kill and asynchronous reset.
module tb_cpu_muldiv_seq;
    localparam int unsigned W   = 32;
    localparam int          LAT = W + 1;

    logic clk;
    logic rst;
    logic kill_4a;

    cpu_muldiv_seq_if #(.WIDTH(W)) mif ();

    cpu_muldiv_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .kill_4a (kill_4a),
        .mds     (mif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    vec_t         vecs[14];
    int           tests = 0;
    int           fails = 0;
    logic [W-1:0] last_res;

    task automatic chk(input string nm, input int tag, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, tag, act, exp);
        end
    endtask

    // Called mid-cycle; issues one op and follows it through to the cycle after DONE.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, input int tag);
        int  lat;
        int  bad;
        bit  seen;
        mif.start_2a = 1'b1;
        mif.op_2a    = op;
        mif.a_2a     = a;
        mif.b_2a     = b;
        #1;
        chk("stall_accept", tag, 64'(mif.stall_2a), 64'd1);
        lat  = 0;
        bad  = 0;
        seen = 1'b0;
        while (!seen && lat < 100) begin
            @(posedge clk);
            #1;
            mif.start_2a = 1'b0;
            lat++;
            #1;
            if (mif.valid_3a === 1'b1) begin
                seen = 1'b1;
            end else if (mif.stall_2a !== 1'b1 || mif.busy !== 1'b1) begin
                bad++;
            end
        end
        chk("latency", tag, 64'(lat), 64'(LAT));
        chk("run_stall_busy", tag, 64'(bad), 64'd0);
        chk("result", tag, 64'(mif.result_3a), 64'(exp));
        chk("done_stall", tag, 64'(mif.stall_2a), 64'd0);
        @(posedge clk);
        #2;
        chk("idle_busy", tag, 64'(mif.busy), 64'd0);
        chk("idle_valid", tag, 64'(mif.valid_3a), 64'd0);
        chk("held_result", tag, 64'(mif.result_3a), 64'(exp));
        last_res = exp;
    endtask

    initial begin
        int nvalid;

        vecs[0]  = '{2'd0, 32'd7,          32'd6,          32'd42};
        vecs[1]  = '{2'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE};
        vecs[2]  = '{2'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001};
        vecs[3]  = '{2'd2, 32'd100,        32'd7,          32'd14};
        vecs[4]  = '{2'd3, 32'd100,        32'd7,          32'd2};
        vecs[5]  = '{2'd2, 32'd5,          32'd0,          32'hFFFF_FFFF};
        vecs[6]  = '{2'd3, 32'd5,          32'd0,          32'd5};
        vecs[7]  = '{2'd1, 32'h8000_0000,  32'd4,          32'd2};
        vecs[8]  = '{2'd0, 32'h1234_5678,  32'h10,         32'h2345_6780};
        vecs[9]  = '{2'd1, 32'h1234_5678,  32'h10,         32'd1};
        vecs[10] = '{2'd2, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF};
        vecs[11] = '{2'd3, 32'hFFFF_FFFF,  32'd10,         32'd5};
        vecs[12] = '{2'd2, 32'd7,          32'd100,        32'd0};
        vecs[13] = '{2'd3, 32'd7,          32'd100,        32'd7};

        rst          = 1'b0;
        kill_4a      = 1'b0;
        mif.start_2a = 1'b0;
        mif.op_2a    = 2'd0;
        mif.a_2a     = '0;
        mif.b_2a     = '0;
        last_res     = '0;
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", 0, 64'(mif.busy), 64'd0);
        chk("rst_valid", 0, 64'(mif.valid_3a), 64'd0);
        chk("rst_stall", 0, 64'(mif.stall_2a), 64'd0);
        chk("rst_result", 0, 64'(mif.result_3a), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, i);
        end

        // Kill during RUN: abort, no valid, previous result retained.
        mif.start_2a = 1'b1;
        mif.op_2a    = 2'd2;
        mif.a_2a     = 32'd1000;
        mif.b_2a     = 32'd10;
        #1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            mif.start_2a = 1'b0;
        end
        kill_4a = 1'b1;
        #1;
        chk("kill_run_stall", 100, 64'(mif.stall_2a), 64'd1);
        @(posedge clk);
        #1;
        kill_4a = 1'b0;
        #1;
        chk("kill_busy", 100, 64'(mif.busy), 64'd0);
        chk("kill_stall", 100, 64'(mif.stall_2a), 64'd0);
        chk("kill_result", 100, 64'(mif.result_3a), 64'(last_res));
        nvalid = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #2;
            if (mif.valid_3a === 1'b1) nvalid++;
        end
        chk("kill_no_valid", 100, 64'(nvalid), 64'd0);
        run_op(2'd0, 32'd3, 32'd3, 32'd9, 101);

        // Kill in DONE: valid suppressed and result register untouched.
        mif.start_2a = 1'b1;
        mif.op_2a    = 2'd2;
        mif.a_2a     = 32'd1000;
        mif.b_2a     = 32'd10;
        #1;
        for (int c = 1; c <= LAT; c++) begin
            @(posedge clk);
            #1;
            mif.start_2a = 1'b0;
            if (c == LAT) kill_4a = 1'b1;
        end
        #1;
        chk("kill_done_valid", 102, 64'(mif.valid_3a), 64'd0);
        chk("kill_done_result", 102, 64'(mif.result_3a), 64'(last_res));
        @(posedge clk);
        #1;
        kill_4a = 1'b0;
        #1;
        chk("kill_done_busy", 102, 64'(mif.busy), 64'd0);
        chk("kill_done_held", 102, 64'(mif.result_3a), 64'(last_res));

        // Start held through DONE, dropped the cycle after: exactly one valid pulse.
        mif.start_2a = 1'b1;
        mif.op_2a    = 2'd0;
        mif.a_2a     = 32'd11;
        mif.b_2a     = 32'd13;
        #1;
        nvalid = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (c == LAT + 1) mif.start_2a = 1'b0;
            #1;
            if (mif.valid_3a === 1'b1) begin
                nvalid++;
                chk("held_start_res", 103, 64'(mif.result_3a), 64'd143);
                chk("held_start_stall", 103, 64'(mif.stall_2a), 64'd0);
            end
        end
        chk("held_start_pulses", 103, 64'(nvalid), 64'd1);
        last_res = 32'd143;

        // Start and kill together in IDLE: kill wins.
        mif.start_2a = 1'b1;
        kill_4a      = 1'b1;
        #1;
        chk("startkill_stall", 104, 64'(mif.stall_2a), 64'd0);
        @(posedge clk);
        #1;
        mif.start_2a = 1'b0;
        kill_4a      = 1'b0;
        #1;
        chk("startkill_busy", 104, 64'(mif.busy), 64'd0);

        // Asynchronous reset in the middle of RUN.
        mif.start_2a = 1'b1;
        mif.op_2a    = 2'd0;
        mif.a_2a     = 32'd5;
        mif.b_2a     = 32'd5;
        #1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #1;
            mif.start_2a = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 105, 64'(mif.busy), 64'd0);
        chk("arst_stall", 105, 64'(mif.stall_2a), 64'd0);
        chk("arst_valid", 105, 64'(mif.valid_3a), 64'd0);
        chk("arst_result", 105, 64'(mif.result_3a), 64'd0);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        run_op(2'd2, 32'd9, 32'd3, 32'd3, 106);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
